// File: rtl/demux_pkg.sv
// Shared constants and types for the 1-to-2 stream demultiplexer.
//   DW     : data width of every stream port
//   DEPTH  : entries per output buffer (two, so pointers are one bit)
//   CNT_W  : width of the per-output delivered-beat counters
//   route_state_t : packet routing state of the input side
package demux_pkg;

    localparam int DW    = 8;
    localparam int DEPTH = 2;
    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROUTE1 = 2'd1,
        ROUTE2 = 2'd2
    } route_state_t;

endpackage

// File: rtl/demux_out_fifo.sv
// Two-entry {last, data} buffer feeding one demux output.
//   clk, rst   : clock, asynchronous active-high reset
//   push       : write push_data/push_last (caller guarantees not full)
//   pop        : drop the head entry (caller guarantees not empty)
//   head_data  : data of the oldest entry
//   head_last  : last flag of the oldest entry
//   full/empty : occupancy flags
module demux_out_fifo
    import demux_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] push_data,
    input  logic          push_last,
    output logic [DW-1:0] head_data,
    output logic          head_last,
    output logic          full,
    output logic          empty
);

    logic [DW:0] mem [DEPTH];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {push_last, push_data};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head_data = mem[rd_ptr][DW-1:0];
    assign head_last = mem[rd_ptr][DW];
    assign full      = (count == 2'd2);
    assign empty     = (count == 2'd0);

endmodule

// File: rtl/demux_1to2_8bits_stream.sv
// Registered 1-to-2 stream demultiplexer. The destination is taken from
// in_sel on the first beat of a packet and held until the beat with in_last.
// Each output has its own two-entry buffer and a wrapping delivered-beat count.
//   clk, rst                         : clock, asynchronous active-high reset
//   in_data/in_valid/in_last/in_sel  : input stream, in_sel 0 -> out1, 1 -> out2
//   in_ready                         : input beat accepted this cycle
//   outN_data/outN_valid/outN_last   : head of output buffer N
//   outN_ready                       : consumer takes the head of buffer N
//   cnt1, cnt2                       : beats delivered on each output
//
// state  | meaning
// IDLE   | waiting for first beat of a packet, destination = in_sel
// ROUTE1 | mid-packet, locked to out1
// ROUTE2 | mid-packet, locked to out2
module demux_1to2_8bits_stream
    import demux_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [DW-1:0]    in_data,
    input  logic             in_valid,
    input  logic             in_last,
    input  logic             in_sel,
    output logic             in_ready,
    output logic [DW-1:0]    out1_data,
    output logic             out1_valid,
    output logic             out1_last,
    input  logic             out1_ready,
    output logic [DW-1:0]    out2_data,
    output logic             out2_valid,
    output logic             out2_last,
    input  logic             out2_ready,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    route_state_t state;
    route_state_t state_nxt;
    logic         dest;
    logic         xfer;
    logic         full1, full2;
    logic         empty1, empty2;
    logic         pop1, pop2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        dest      = 1'b0;
        case (state)
            IDLE: begin
                dest = in_sel;
                if (xfer && !in_last) begin
                    state_nxt = in_sel ? ROUTE2 : ROUTE1;
                end
            end
            ROUTE1: begin
                dest = 1'b0;
                if (xfer && in_last) begin
                    state_nxt = IDLE;
                end
            end
            ROUTE2: begin
                dest = 1'b1;
                if (xfer && in_last) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Ready looks only at the destination's full flag, never at outN_ready,
    // so a full buffer refuses a beat even while it is being popped.
    assign in_ready = ~rst & ~(dest ? full2 : full1);
    assign xfer     = in_valid & in_ready;

    assign out1_valid = ~empty1;
    assign out2_valid = ~empty2;
    assign pop1       = out1_valid & out1_ready;
    assign pop2       = out2_valid & out2_ready;

    demux_out_fifo u_fifo1 (
        .clk       (clk),
        .rst       (rst),
        .push      (xfer & ~dest),
        .pop       (pop1),
        .push_data (in_data),
        .push_last (in_last),
        .head_data (out1_data),
        .head_last (out1_last),
        .full      (full1),
        .empty     (empty1)
    );

    demux_out_fifo u_fifo2 (
        .clk       (clk),
        .rst       (rst),
        .push      (xfer & dest),
        .pop       (pop2),
        .push_data (in_data),
        .push_last (in_last),
        .head_data (out2_data),
        .head_last (out2_last),
        .full      (full2),
        .empty     (empty2)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt1 <= '0;
            cnt2 <= '0;
        end else begin
            if (pop1) cnt1 <= cnt1 + CNT_ONE;
            if (pop2) cnt2 <= cnt2 + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_demux_1to2_8bits_stream.sv
// Directed bench for the 1-to-2 stream demultiplexer. Inputs change 1 ns
// after a rising edge, outputs are sampled at that same point.
module tb_demux_1to2_8bits_stream;

    logic        clk;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_sel;
    logic        in_ready;
    logic [7:0]  out1_data;
    logic        out1_valid;
    logic        out1_last;
    logic        out1_ready;
    logic [7:0]  out2_data;
    logic        out2_valid;
    logic        out2_last;
    logic        out2_ready;
    logic [15:0] cnt1;
    logic [15:0] cnt2;

    int checks   = 0;
    int failures = 0;

    demux_1to2_8bits_stream dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_sel     (in_sel),
        .in_ready   (in_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_last  (out1_last),
        .out1_ready (out1_ready),
        .out2_data  (out2_data),
        .out2_valid (out2_valid),
        .out2_last  (out2_last),
        .out2_ready (out2_ready),
        .cnt1       (cnt1),
        .cnt2       (cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic s);
        in_valid = v;
        in_data  = d;
        in_last  = l;
        in_sel   = s;
    endtask

    initial begin
        rst        = 1'b1;
        out1_ready = 1'b1;
        out2_ready = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        tick();
        check_val("rst_in_ready", in_ready, 0);
        check_val("rst_out1_valid", out1_valid, 0);
        check_val("rst_out1_data", out1_data, 8'h00);
        check_val("rst_out2_valid", out2_valid, 0);
        check_val("rst_cnt1", cnt1, 0);
        check_val("rst_cnt2", cnt2, 0);
        rst = 1'b0;
        #1;
        check_val("post_rst_in_ready", in_ready, 1);

        // single-beat packets to each output
        drive(1'b1, 8'h11, 1'b1, 1'b0);
        tick();
        check_val("sb1_valid", out1_valid, 1);
        check_val("sb1_data", out1_data, 8'h11);
        check_val("sb1_last", out1_last, 1);
        check_val("sb1_out2_idle", out2_valid, 0);
        drive(1'b1, 8'h22, 1'b1, 1'b1);
        tick();
        check_val("sb2_valid", out2_valid, 1);
        check_val("sb2_data", out2_data, 8'h22);
        check_val("sb2_last", out2_last, 1);
        check_val("sb2_out1_drained", out1_valid, 0);
        check_val("sb_cnt1", cnt1, 1);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        check_val("sb_cnt2", cnt2, 1);

        // four-beat packet locked to out1 while in_sel toggles
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'hA0 + 8'(i), (i == 3), i[0]);
            tick();
            check_val("pkt4_data", out1_data, 8'hA0 + i);
            check_val("pkt4_last", out1_last, (i == 3) ? 1 : 0);
            check_val("pkt4_out2_idle", out2_valid, 0);
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        check_val("pkt4_cnt1", cnt1, 5);
        check_val("pkt4_cnt2", cnt2, 1);

        // back-pressure on out1: two accepted, third waits
        out1_ready = 1'b0;
        drive(1'b1, 8'hB0, 1'b0, 1'b0);
        #1;
        check_val("bp_ready0", in_ready, 1);
        tick();
        drive(1'b1, 8'hB1, 1'b0, 1'b1);
        #1;
        check_val("bp_ready1", in_ready, 1);
        tick();
        drive(1'b1, 8'hB2, 1'b1, 1'b1);
        #1;
        check_val("bp_full_ready", in_ready, 0);
        check_val("bp_head0", out1_data, 8'hB0);
        tick();
        check_val("bp_hold_ready", in_ready, 0);
        out1_ready = 1'b1;
        #1;
        check_val("full_pop_ready", in_ready, 0);
        tick();
        check_val("freed_ready", in_ready, 1);
        check_val("bp_head1", out1_data, 8'hB1);
        tick();
        check_val("bp_head2", out1_data, 8'hB2);
        check_val("bp_head2_last", out1_last, 1);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        check_val("bp_drained", out1_valid, 0);
        check_val("bp_cnt1", cnt1, 8);

        // out1 full and stalled; new packet from IDLE goes to out2
        out1_ready = 1'b0;
        drive(1'b1, 8'hC0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 8'hC1, 1'b1, 1'b1);
        tick();
        drive(1'b1, 8'hD0, 1'b1, 1'b0);
        #1;
        check_val("ind_sel0_ready", in_ready, 0);
        drive(1'b1, 8'hD0, 1'b1, 1'b1);
        #1;
        check_val("ind_sel1_ready", in_ready, 1);
        tick();
        check_val("ind_out2_valid", out2_valid, 1);
        check_val("ind_out2_data", out2_data, 8'hD0);
        check_val("ind_out1_head", out1_data, 8'hC0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        check_val("ind_cnt2", cnt2, 2);
        check_val("ind_cnt1", cnt1, 8);

        // reset mid-packet with two beats queued on out2
        out2_ready = 1'b0;
        drive(1'b1, 8'hE0, 1'b0, 1'b1);
        tick();
        drive(1'b1, 8'hE1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check_val("mid_out2_valid", out2_valid, 1);
        check_val("mid_out2_data", out2_data, 8'hE0);
        #2;
        rst = 1'b1;
        #1;
        check_val("mrst_out2_valid", out2_valid, 0);
        check_val("mrst_cnt2", cnt2, 0);
        check_val("mrst_cnt1", cnt1, 0);
        check_val("mrst_out1_valid", out1_valid, 0);
        check_val("mrst_in_ready", in_ready, 0);
        #2;
        rst        = 1'b0;
        out1_ready = 1'b1;
        out2_ready = 1'b1;
        drive(1'b1, 8'hF0, 1'b1, 1'b0);
        #1;
        check_val("rel_in_ready", in_ready, 1);
        tick();
        check_val("rel_out1_valid", out1_valid, 1);
        check_val("rel_out1_data", out1_data, 8'hF0);
        check_val("rel_out2_valid", out2_valid, 0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        check_val("rel_cnt1", cnt1, 1);
        check_val("rel_cnt2", cnt2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
